rgmii_rx_stream_gen: RTL
========================

// Module: rgmii_rx_stream_gen
// PURPOSE
//  PHY-side RGMII receive-stream generator for loopback and PHY emulation.
//  Takes MAC nibbles over a valid/ready stream and adds preamble/SFD.
//  Enforces the inter-frame gap and encodes in-band link status while idle.
//  Outputs are per-edge SDR values; external ODDRs drive the RGMII RX pins.
//  Same 10/100 nibble convention as the RGMII-to-MII converter.
// PARAMETERS
//  ADD_PREAMBLE     1   1: prepend PREAMBLE_NIBBLES x 0x5 + one 0xD (SFD); 0: none
//  PREAMBLE_NIBBLES 15  preamble length in nibbles, excluding the SFD (1..15)
//  IFG_NIBBLES      24  minimum idle nibbles after each frame (1..255)
// PORTS
//  clk          in   1  stream clock (2.5/25 MHz), single clock domain
//  rstn         in   1  asynchronous active-low reset
//  s_valid      in   1  source nibble valid
//  s_ready      out  1  source nibble accepted when s_valid & s_ready
//  s_data       in   4  source nibble, LSN first
//  s_last       in   1  last nibble of frame
//  s_err        in   1  nibble carries a receive error
//  link_up      in   1  status to encode in-band
//  speed        in   2  00=10M 01=100M 10=1G 11=reserved (encoded as 10M)
//  full_duplex  in   1  status to encode in-band
//  d_rise       out  4  RXD value for the rising edge
//  d_fall       out  4  RXD value for the falling edge (always = d_rise)
//  ctl_rise     out  1  RX_CTL rising edge = dv
//  ctl_fall     out  1  RX_CTL falling edge = dv ^ er
//  frames_sent  out 16  count of completed frames, wraps at 0xFFFF
//  frames_abort out 16  count of underrun-aborted or dropped frames, wraps at 0xFFFF
// BEHAVIOUR
//  - All outputs except s_ready are registered: 1 cycle latency from decision to pins.
//  - Reset values: d_* = 0, ctl_* = 0, counters = 0, state = IDLE.
//    status_q = {0,00,0}: link down, 10M, half duplex.
//  - Idle encoding (IDLE, IFG): ctl = 00, d = {dup_q, spd_q[1:0], link_q}.
//    Gives 0x1/0x3/0x5 for 10M/100M/1G with link up; bit3 = duplex.
//  - Status is re-latched every cycle in IDLE only, frozen from frame start through the IFG.
//  - States:
//    IDLE: s_ready = 0.
//      s_valid & link_q    -> PREAMBLE (ADD_PREAMBLE = 1) or DATA.
//      s_valid & !link_q   -> DROP.
//    PREAMBLE: emit ctl = 11, d = 0x5 for PREAMBLE_NIBBLES cycles, then d = 0xD for one cycle, then DATA.
//      s_ready = 0.
//    DATA: s_ready = 1.
//      Accepted nibble -> d = s_data; ctl = {1, ~s_err}, i.e. er = s_err.
//      s_last accepted -> IFG, frames_sent++.
//      !s_valid (underrun) -> emit d = 0x0 with ctl = 10 (dv = 1, er = 1); then ABORT, frames_abort++.
//    ABORT, DROP: s_ready = 1; discard until s_valid & s_last, then IFG.
//      Outputs: ABORT emits idle; DROP emits idle. DROP also does frames_abort++ on entry.
//    IFG: s_ready = 0; emit idle for IFG_NIBBLES cycles, then IDLE. Counter is 8 bits.
//  - Edge cases:
//    - s_last on the first data nibble gives a 1-nibble frame and is legal.
//    - Inputs s_valid and s_last in ABORT on the same cycle as entry: exit to IFG next cycle.
//    - link_up dropping mid-frame is ignored until IDLE.
//    - Reset mid-frame: outputs drop to 00 idle immediately (async). No frame counters change.
//  - ctl = 01 (dv = 0, er = 1, carrier codes) is never generated.
// STRUCTURE
//  - Package rgmii_pkg: state enum, SPEED_10M/100M/1G codes, PREAMBLE_NIBBLE = 4'h5, SFD_NIBBLE = 4'hD, idle-encoding function.
//  - Single module, no sub-modules; ODDR instantiation stays in the wrapper.
// TESTING
//  - Reset with link_up = 1, speed = 01, full_duplex = 1:
//    Before reset release: d = 0x0, ctl = 00.
//    One cycle after release: d = 0xB, ctl = 00.
//  - 4-nibble frame A,B,C,D (last on D), defaults:
//    15 x 0x5 then 0xD (ctl 11), then A..D (ctl 11), then 24 idle cycles. frames_sent = 1.
//  - Back-to-back frames with s_valid held high:
//    Second preamble starts exactly 24 + 1 cycles after the last nibble of frame 1.
//  - Underrun after 2 nibbles, then 3 more nibbles with last:
//    One nibble with ctl = 10, d = 0; remainder discarded; frames_abort = 1; IFG follows.
//  - link_up = 0 with a 5-nibble frame offered:
//    All 5 accepted; no ctl = 11 on the output; frames_abort = 1; d stays 0x0/0x2 per speed.
//  - s_err on nibble 3 of 6: only that cycle has ctl_fall = 0. Frame completes and frames_sent increments.

Source files
------------

// File: rtl/rgmii_pkg.sv
// Shared types, constants and in-band status encoding for the RGMII
// receive-stream generator.
package rgmii_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_DATA,
        ST_ABORT,
        ST_DROP,
        ST_IFG
    } rx_state_e;

    localparam logic [1:0] SPEED_10M  = 2'b00;
    localparam logic [1:0] SPEED_100M = 2'b01;
    localparam logic [1:0] SPEED_1G   = 2'b10;

    localparam logic [3:0] PREAMBLE_NIBBLE = 4'h5;
    localparam logic [3:0] SFD_NIBBLE      = 4'hD;

    typedef struct packed {
        logic       dup;
        logic [1:0] spd;
        logic       link;
    } link_status_t;

    // Reserved speed code 11 is reported as 10M.
    function automatic link_status_t latch_status(input logic       link,
                                                  input logic [1:0] speed,
                                                  input logic       dup);
        link_status_t s;
        s.dup  = dup;
        s.spd  = (speed == 2'b11) ? SPEED_10M : speed;
        s.link = link;
        return s;
    endfunction

    function automatic logic [3:0] idle_nibble(input link_status_t s);
        return {s.dup, s.spd, s.link};
    endfunction

endpackage

// File: rtl/rgmii_rx_stream_gen.sv
// PHY-side RGMII receive-stream generator: frames MAC nibbles with preamble/SFD,
// enforces the inter-frame gap and encodes link status in-band while idle.
module rgmii_rx_stream_gen
    import rgmii_pkg::*;
#(
    parameter int unsigned ADD_PREAMBLE     = 1,
    parameter int unsigned PREAMBLE_NIBBLES = 15,
    parameter int unsigned IFG_NIBBLES      = 24
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [3:0]  s_data,
    input  logic        s_last,
    input  logic        s_err,
    input  logic        link_up,
    input  logic [1:0]  speed,
    input  logic        full_duplex,
    output logic [3:0]  d_rise,
    output logic [3:0]  d_fall,
    output logic        ctl_rise,
    output logic        ctl_fall,
    output logic [15:0] frames_sent,
    output logic [15:0] frames_abort
);

    localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_NIBBLES);
    localparam logic [7:0] IFG_LAST = 8'(IFG_NIBBLES - 1);

    rx_state_e    state_q, state_d;
    link_status_t status_q, status_d, status_in;
    logic [7:0]   cnt_q, cnt_d;
    logic [3:0]   d_q, d_d;
    logic         ctl_r_q, ctl_r_d;
    logic         ctl_f_q, ctl_f_d;
    logic [15:0]  sent_q, sent_d;
    logic [15:0]  abort_q, abort_d;

    always_comb begin
        status_in = latch_status(link_up, speed, full_duplex);
        state_d   = state_q;
        status_d  = status_q;
        cnt_d     = cnt_q;
        d_d       = idle_nibble(status_q);
        ctl_r_d   = 1'b0;
        ctl_f_d   = 1'b0;
        sent_d    = sent_q;
        abort_d   = abort_q;
        s_ready   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Status tracks the pins while idle; the frame decision uses the
                // previously latched link bit.
                status_d = status_in;
                d_d      = idle_nibble(status_in);
                cnt_d    = '0;
                if (s_valid) begin
                    if (status_q.link) begin
                        state_d = (ADD_PREAMBLE != 0) ? ST_PREAMBLE : ST_DATA;
                    end else begin
                        state_d = ST_DROP;
                        abort_d = abort_q + 16'd1;
                    end
                end
            end

            ST_PREAMBLE: begin
                ctl_r_d = 1'b1;
                ctl_f_d = 1'b1;
                if (cnt_q == PRE_LAST) begin
                    d_d     = SFD_NIBBLE;
                    state_d = ST_DATA;
                end else begin
                    d_d   = PREAMBLE_NIBBLE;
                    cnt_d = cnt_q + 8'd1;
                end
            end

            ST_DATA: begin
                s_ready = 1'b1;
                ctl_r_d = 1'b1;
                if (s_valid) begin
                    d_d     = s_data;
                    ctl_f_d = ~s_err;
                    if (s_last) begin
                        state_d = ST_IFG;
                        cnt_d   = '0;
                        sent_d  = sent_q + 16'd1;
                    end
                end else begin
                    // Underrun: flag the frame as errored, then swallow the rest.
                    d_d     = '0;
                    ctl_f_d = 1'b0;
                    state_d = ST_ABORT;
                    abort_d = abort_q + 16'd1;
                end
            end

            ST_ABORT, ST_DROP: begin
                s_ready = 1'b1;
                if (s_valid && s_last) begin
                    state_d = ST_IFG;
                    cnt_d   = '0;
                end
            end

            ST_IFG: begin
                if (cnt_q == IFG_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            status_q <= '0;
            cnt_q    <= '0;
            d_q      <= '0;
            ctl_r_q  <= 1'b0;
            ctl_f_q  <= 1'b0;
            sent_q   <= '0;
            abort_q  <= '0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            cnt_q    <= cnt_d;
            d_q      <= d_d;
            ctl_r_q  <= ctl_r_d;
            ctl_f_q  <= ctl_f_d;
            sent_q   <= sent_d;
            abort_q  <= abort_d;
        end
    end

    assign d_rise       = d_q;
    assign d_fall       = d_q;
    assign ctl_rise     = ctl_r_q;
    assign ctl_fall     = ctl_f_q;
    assign frames_sent  = sent_q;
    assign frames_abort = abort_q;

endmodule
